// File: rtl/risc_mem_responder.sv
// Memory-side responder for the pipelined RISC core: instruction memory with byte-serial loader,
// data memory, and a small MMIO window (GPIO out/in, free-running cycle counter).
module risc_mem_responder #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  imem_addr,
  output logic [31:0] imem_data,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_wdata,
  input  logic        ram_we,
  output logic [31:0] ram_rdata,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        core_hold,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out
);

  // Depths are powers of two no larger than the address spaces, so mod is a bit slice.
  localparam int unsigned IW = $clog2(IMEM_WORDS);
  localparam int unsigned DW = $clog2(DMEM_WORDS);
  localparam logic [IW-1:0] PtrLast     = IW'(IMEM_WORDS - 1);
  localparam logic [31:0]   AddrGpioOut = 32'h8000_0000;
  localparam logic [31:0]   AddrGpioIn  = 32'h8000_0001;
  localparam logic [31:0]   AddrCycle   = 32'h8000_0002;

  typedef enum logic [1:0] {StIdle, StLoad, StRelease} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [1:0]    k_q, k_d;
  logic [31:0]   asm_q, asm_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [7:0]    gpio_q, gpio_d;

  logic [31:0]   word;
  logic          imem_we;
  logic          dmem_we;
  logic          mmio_sel;
  logic [DW-1:0] dmem_idx;

  logic [31:0]   imem_mem [IMEM_WORDS];
  logic [31:0]   dmem_mem [DMEM_WORDS];

  // Loader FSM
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    asm_d   = asm_q;
    imem_we = 1'b0;
    word    = asm_q;
    word[{k_q, 3'b000} +: 8] = ld_byte;
    unique case (state_q)
      StIdle: begin
        if (ld_start) begin
          state_d = StLoad;
          ptr_d   = '0;
          k_d     = '0;
          asm_d   = '0;
        end
      end
      StLoad: begin
        if (ld_valid) begin
          if (k_q == 2'd3 || ld_last) begin
            // Assembly register is zero above byte k, so short final words are zero-padded.
            imem_we = !rst_n;
            ptr_d   = ptr_q + IW'(1);
            k_d     = '0;
            asm_d   = '0;
            if (ld_last || ptr_q == PtrLast) begin
              state_d = StRelease;
            end
          end else begin
            asm_d = word;
            k_d   = k_q + 2'd1;
          end
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign core_hold = (state_q != StIdle);
  assign ld_ready  = (state_q == StLoad);

  // Data side: counter, GPIO register, DMEM write enable
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && ld_start) begin
      cnt_d = '0;
    end else if (!core_hold) begin
      cnt_d = cnt_q + 32'd1;
    end
    gpio_d = gpio_q;
    if (ram_we && !core_hold && ram_addr == AddrGpioOut) begin
      gpio_d = ram_wdata[7:0];
    end
  end

  assign mmio_sel = ram_addr[31];
  assign dmem_idx = ram_addr[DW-1:0];
  assign dmem_we  = ram_we && !core_hold && !mmio_sel && !rst_n;

  always_comb begin
    ram_rdata = '0;
    if (!mmio_sel) begin
      ram_rdata = dmem_mem[dmem_idx];
    end else begin
      case (ram_addr)
        AddrGpioOut: ram_rdata = {24'b0, gpio_q};
        AddrGpioIn:  ram_rdata = {24'b0, gpio_in};
        AddrCycle:   ram_rdata = cnt_q;
        default:     ram_rdata = '0;
      endcase
    end
  end

  assign imem_data = core_hold ? 32'b0 : imem_mem[imem_addr[IW-1:0]];
  assign gpio_out  = gpio_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      k_q     <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
      gpio_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      gpio_q  <= gpio_d;
    end
  end

  // Memories keep their contents across reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_mem[ptr_q] <= word;
    end
    if (dmem_we) begin
      dmem_mem[dmem_idx] <= ram_wdata;
    end
  end

endmodule

// File: tb/tb_risc_mem_responder.sv
// Self-checking bench for risc_mem_responder: directed literal checks plus a randomized run
// compared every cycle against a queue/array based reference model.
module tb_risc_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        core_hold;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;

  always #5 clk = ~clk;

  risc_mem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .core_hold (core_hold),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 loading, 2 releasing
  bit          model_ok = 1'b0;
  int          mode;
  int          ptr_m;
  logic [7:0]  pend [$];
  logic [31:0] imem_m [256];
  bit          imem_k [256];
  logic [31:0] dmem_m [64];
  bit          dmem_k [64];
  logic [7:0]  gpio_m;
  logic [31:0] cnt_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_update();
    bit          hold;
    logic [31:0] w;
    if (rst_n) begin
      mode     = 0;
      ptr_m    = 0;
      cnt_m    = 0;
      gpio_m   = 0;
      pend.delete();
      model_ok = 1'b1;
    end else begin
      hold = (mode != 0);
      if (ram_we && !hold) begin
        if (!ram_addr[31]) begin
          dmem_m[int'(ram_addr % 64)] = ram_wdata;
          dmem_k[int'(ram_addr % 64)] = 1'b1;
        end else if (ram_addr == 32'h8000_0000) begin
          gpio_m = ram_wdata[7:0];
        end
      end
      if (mode == 0 && ld_start) cnt_m = 0;
      else if (!hold)            cnt_m = cnt_m + 1;
      case (mode)
        0: if (ld_start) begin
          mode  = 1;
          ptr_m = 0;
          pend.delete();
        end
        1: if (ld_valid) begin
          pend.push_back(ld_byte);
          if (pend.size() == 4 || ld_last) begin
            w = 0;
            foreach (pend[i]) w = w | (32'(pend[i]) << (8 * i));
            imem_m[ptr_m] = w;
            imem_k[ptr_m] = 1'b1;
            if (ld_last || ptr_m == 255) mode = 2;
            ptr_m = ptr_m + 1;
            pend.delete();
          end
        end
        default: mode = 0;
      endcase
    end
  endtask

  // Per-cycle comparison of every output against the model
  logic [31:0] exp_rd;
  bit          rd_known;
  always @(negedge clk) begin
    if (model_ok) begin
      check("core_hold", 32'(core_hold), 32'(mode != 0));
      check("ld_ready", 32'(ld_ready), 32'(mode == 1));
      check("gpio_out", 32'(gpio_out), 32'(gpio_m));
      if (mode != 0) check("imem_data_held", imem_data, 32'h0);
      else if (imem_k[imem_addr]) check("imem_data", imem_data, imem_m[imem_addr]);
      rd_known = 1'b1;
      exp_rd   = 32'h0;
      if (!ram_addr[31]) begin
        rd_known = dmem_k[int'(ram_addr % 64)];
        exp_rd   = dmem_m[int'(ram_addr % 64)];
      end else if (ram_addr == 32'h8000_0000) exp_rd = {24'b0, gpio_m};
      else if (ram_addr == 32'h8000_0001) exp_rd = {24'b0, gpio_in};
      else if (ram_addr == 32'h8000_0002) exp_rd = cnt_m;
      if (rd_known) check("ram_rdata", ram_rdata, exp_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic load(input logic [7:0] b[$], input int last_at);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    foreach (b[i]) begin
      ld_valid = 1'b1;
      ld_byte  = b[i];
      ld_last  = (i == last_at);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  logic [7:0] bq [$];

  initial begin
    rst_n = 1'b1; imem_addr = '0; ram_addr = '0; ram_wdata = '0; ram_we = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0; gpio_in = '0;
    tick();
    tick();
    rst_n = 1'b0;

    // Reset state and first counter reads
    ram_addr = 32'h8000_0002;
    @(negedge clk);
    check("rst_cnt0", ram_rdata, 32'h0);
    check("rst_hold", 32'(core_hold), 32'h0);
    check("rst_ready", 32'(ld_ready), 32'h0);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    tick();
    @(negedge clk);
    check("rst_cnt1", ram_rdata, 32'h1);
    tick();

    // Fill DMEM, then same-cycle read/write and aliasing
    for (int i = 0; i < 64; i++) begin
      ram_we = 1'b1; ram_addr = 32'(i); ram_wdata = $urandom;
      tick();
    end
    ram_addr = 32'd5; ram_wdata = 32'h1234_5678;
    tick();
    ram_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("dmem_old", ram_rdata, 32'h1234_5678);
    tick();
    ram_we = 1'b0;
    @(negedge clk);
    check("dmem_new", ram_rdata, 32'hDEAD_BEEF);
    ram_we = 1'b1; ram_addr = 32'd69; ram_wdata = 32'hCAFE_F00D;
    tick();
    ram_we = 1'b0; ram_addr = 32'd5;
    @(negedge clk);
    check("dmem_alias", ram_rdata, 32'hCAFE_F00D);

    // Full-word load
    bq = {8'h13, 8'h05, 8'h10, 8'h00};
    load(bq, 3);
    imem_addr = 8'd0;
    @(negedge clk);
    check("full_release_hold", 32'(core_hold), 32'h1);
    check("full_release_imem", imem_data, 32'h0);
    tick();
    @(negedge clk);
    check("full_idle_hold", 32'(core_hold), 32'h0);
    check("full_imem0", imem_data, 32'h0010_0513);

    // Two words, last on the 8th byte
    bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    load(bq, 7);
    tick();
    @(negedge clk);
    check("part_imem0", imem_data, 32'hDDCC_BBAA);
    imem_addr = 8'd1;
    #1;
    check("part_imem1", imem_data, 32'h4433_2211);

    // Last on byte 22: short word zero-padded
    bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    load(bq, 5);
    @(negedge clk);
    check("short_ready_low", 32'(ld_ready), 32'h0);
    tick();
    @(negedge clk);
    check("short_imem1", imem_data, 32'h0000_2211);

    // MMIO
    ram_we = 1'b1; ram_addr = 32'h8000_0000; ram_wdata = 32'h0000_01A5;
    tick();
    ram_we = 1'b0;
    @(negedge clk);
    check("gpio_write", 32'(gpio_out), 32'hA5);
    gpio_in = 8'h3C; ram_addr = 32'h8000_0001;
    #1;
    check("gpio_in_read", ram_rdata, 32'h0000_003C);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ram_we = 1'b1; ram_addr = 32'h8000_0000; ram_wdata = 32'h77;
    tick();
    ram_we = 1'b0;
    @(negedge clk);
    check("gpio_hold_write", 32'(gpio_out), 32'hA5);
    ld_valid = 1'b1; ld_byte = 8'h00; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();

    // Abort after two words
    bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    load(bq, -1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    imem_addr = 8'd0;
    @(negedge clk);
    check("abort_hold", 32'(core_hold), 32'h0);
    check("abort_ready", 32'(ld_ready), 32'h0);
    check("abort_imem0", imem_data, 32'h0403_0201);
    imem_addr = 8'd1;
    #1;
    check("abort_imem1", imem_data, 32'h0807_0605);
    tick();

    // Overflow: 1024 bytes without ld_last, plus trailing bytes
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 1028; i++) begin
      ld_valid = 1'b1; ld_byte = 8'(i); ld_last = 1'b0;
      tick();
      if (i == 1023) begin
        @(negedge clk);
        check("ovf_release_hold", 32'(core_hold), 32'h1);
        check("ovf_release_ready", 32'(ld_ready), 32'h0);
      end
      if (i == 1024) begin
        @(negedge clk);
        check("ovf_idle_hold", 32'(core_hold), 32'h0);
      end
    end
    ld_valid = 1'b0;
    imem_addr = 8'd255;
    @(negedge clk);
    check("ovf_imem255", imem_data, 32'hFFFE_FDFC);
    imem_addr = 8'd0;
    #1;
    check("ovf_imem0", imem_data, 32'h0302_0100);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 499) == 0);
      ld_start  = ($urandom_range(0, 59) == 0);
      ld_valid  = 1'($urandom_range(0, 1));
      ld_byte   = 8'($urandom);
      ld_last   = ($urandom_range(0, 15) == 0);
      imem_addr = 8'($urandom);
      gpio_in   = 8'($urandom);
      ram_we    = 1'($urandom_range(0, 1));
      ram_wdata = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    ram_addr = 32'($urandom_range(0, 255));
        2:       ram_addr = 32'h8000_0000 + 32'($urandom_range(0, 4));
        default: ram_addr = $urandom;
      endcase
      tick();
    end
    rst_n = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_mem_responder.md
Name: risc_mem_responder

Overview:
- Memory-side responder for the pipelined RISC core. It serves the core's 8-bit instruction-fetch port and its 32-bit data RAM port.
- Contains a word-addressed instruction memory, a data memory, and a small memory-mapped I/O window (GPIO plus cycle counter).
- A byte-serial program loader fills instruction memory from the Tiny Tapeout pins. The core is held in reset through core_hold while loading.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words; index = imem_addr mod IMEM_WORDS.
- DMEM_WORDS, 64, data memory depth in 32-bit words; index = ram_addr mod DMEM_WORDS.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset; synchronous, active-high despite the name.
- imem_addr  input  8  instruction word address from the core PC.
- imem_data  output  32  instruction word to the core.
- ram_addr  input  32  data word address from the core MEM stage.
- ram_wdata  input  32  store data.
- ram_we  input  1  store strobe.
- ram_rdata  output  32  load data to the core.
- ld_start  input  1  one-cycle pulse that begins a program load at word 0.
- ld_valid  input  1  ld_byte is valid this cycle.
- ld_byte  input  8  program byte, little-endian within each word.
- ld_last  input  1  marks the final byte of the program; sampled with ld_valid.
- ld_ready  output  1  loader accepts a byte this cycle.
- core_hold  output  1  holds the core in reset while high.
- gpio_in  input  8  external input pins.
- gpio_out  output  8  MMIO output register.

Behaviour:
- Reset (rst_n=1 at an edge):
  - state=IDLE, core_hold=0, ld_ready=0, gpio_out=0, cycle counter=0.
  - Word pointer=0, byte index=0, assembly register=0.
  - Memory arrays are not cleared. Reset mid-load aborts the load; words already written are kept.
- FSM states: IDLE, LOAD, RELEASE.
- IDLE:
  - core_hold=0, ld_ready=0.
  - ld_start=1 moves to LOAD next cycle and sets pointer=0, byte index=0, assembly register=0.
- LOAD:
  - core_hold=1, ld_ready=1.
  - On ld_valid, the byte goes to assembly bits [8k+7:8k], where k is the byte index, then k increments.
  - When k=3, or when ld_last=1, the completed word (unfilled upper bytes = 0) is written to imem[pointer] at that edge, the pointer increments, and k returns to 0.
  - ld_last accepted: go to RELEASE.
  - A word write at pointer=IMEM_WORDS-1 also goes to RELEASE. Trailing bytes are not accepted.
  - ld_start while in LOAD is ignored.
- RELEASE:
  - Lasts exactly one cycle: core_hold=1, ld_ready=0.
  - Then IDLE; core_hold falls to 0 one cycle after the last write.
- Instruction port:
  - imem_data = imem[imem_addr mod IMEM_WORDS], combinational, with zero fetch latency.
  - While core_hold=1, imem_data=0.
- Data port decode:
  - ram_addr[31]=0 selects DMEM at index ram_addr mod DMEM_WORDS.
  - ram_addr[31]=1 selects MMIO.
- DMEM:
  - Read is combinational.
  - Write occurs at the clock edge when ram_we=1 and core_hold=0.
  - Read and write to the same address in one cycle: ram_rdata shows the old value; the new value is visible the next cycle.
- MMIO map:
  - 0x8000_0000: read returns {24'b0, gpio_out}; a write loads ram_wdata[7:0] into gpio_out.
  - 0x8000_0001: read returns {24'b0, gpio_in}, with no synchronizer inside the block.
  - 0x8000_0002: read returns the 32-bit cycle counter. It increments every cycle while core_hold=0, wraps 0xFFFF_FFFF to 0, and is cleared on entry to LOAD.
  - Other MMIO addresses read 0; writes to them are ignored.
- ram_we is ignored while core_hold=1, covering both DMEM and gpio_out.

Test Plan:
- Reset, then read: after reset, gpio_out=0, core_hold=0, ld_ready=0; reading 0x8000_0002 on the first non-reset cycle returns 0 and on the next cycle returns 1.
- Full-word load: ld_start, then bytes 13,05,10,00 (last on 00) → imem[0]=0x0010_0513. core_hold stays 1 for one cycle after the write. With imem_addr=0, imem_data=0x0010_0513 once core_hold=0.
- Partial-word load: 8 bytes AA,BB,CC,DD,11,22,33 and then 44 with ld_last → imem[0]=0xDDCC_BBAA, imem[1]=0x4433_2211. With ld_last instead on byte 22: imem[1]=0x0000_2211 and ld_ready=0 on the following cycle.
- DMEM write/read: write 0xDEAD_BEEF to address 5, read address 5 in the same cycle and then the next cycle → old value, then 0xDEAD_BEEF. Write to address 69 with DMEM_WORDS=64 aliases to index 5.
- MMIO: write 0x0000_01A5 to 0x8000_0000 → gpio_out=0xA5. With gpio_in=0x3C, a read of 0x8000_0001 returns 0x0000_003C. A write of 0x77 while core_hold=1 leaves gpio_out=0xA5.
- Abort and overflow: reset asserted after 2 words of a load → IDLE, core_hold=0, imem[0..1] retained. A 1024-byte load with no ld_last leaves RELEASE after the word-255 write.
